// File: rtl/tap_gesture_counter_mc.sv
// Multi-channel debounced tap/gesture counter: per-channel synchroniser, debouncer and
// gesture FSM feeding one-entry result slots drained by a round-robin valid/ready port.
module tap_gesture_counter_mc #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 75_000_000,
  parameter int unsigned COUNT_WIDTH     = 8,
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      button_raw,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CH_W-1:0]        res_ch,
  output logic [COUNT_WIDTH-1:0] res_count,
  output logic                   res_long,
  output logic [NUM_CH-1:0]      overflow
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int unsigned GAP_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HELD     = 2'd1;
  localparam logic [1:0] S_GAP      = 2'd2;
  localparam logic [1:0] S_LONGWAIT = 2'd3;

  logic [NUM_CH-1:0]      sync1_q, sync2_q;
  logic [NUM_CH-1:0]      db_q, db_d;
  logic [DB_W-1:0]        db_cnt_q [NUM_CH];
  logic [DB_W-1:0]        db_cnt_d [NUM_CH];
  logic [1:0]             state_q [NUM_CH];
  logic [1:0]             state_d [NUM_CH];
  logic [COUNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [HOLD_W-1:0]      hold_q [NUM_CH];
  logic [HOLD_W-1:0]      hold_d [NUM_CH];
  logic [GAP_W-1:0]       gap_q [NUM_CH];
  logic [GAP_W-1:0]       gap_d [NUM_CH];
  logic [NUM_CH-1:0]      emit_c, emit_long_c;

  logic [NUM_CH-1:0]      slot_full_q, slot_full_d;
  logic [NUM_CH-1:0]      slot_long_q, slot_long_d;
  logic [COUNT_WIDTH-1:0] slot_cnt_q [NUM_CH];
  logic [COUNT_WIDTH-1:0] slot_cnt_d [NUM_CH];
  logic [NUM_CH-1:0]      overflow_q, overflow_d;

  logic                   grant_vld_c;
  logic [CH_W-1:0]        grant_idx_c;
  logic                   res_valid_q, res_valid_d;
  logic                   res_long_q, res_long_d;
  logic [CH_W-1:0]        res_ch_q, res_ch_d;
  logic [COUNT_WIDTH-1:0] res_count_q, res_count_d;
  logic [CH_W-1:0]        rr_q, rr_d;

  // Debounce and gesture FSM; the FSM follows the debounced level, so level tests act as edges.
  always_comb begin
    db_d        = db_q;
    emit_c      = '0;
    emit_long_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      db_cnt_d[i] = '0;
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      hold_d[i]   = hold_q[i];
      gap_d[i]    = gap_q[i];
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) db_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
      case (state_q[i])
        S_IDLE: begin
          if (db_q[i]) begin
            state_d[i] = S_HELD;
            cnt_d[i]   = COUNT_WIDTH'(1);
            hold_d[i]  = '0;
          end
        end
        S_HELD: begin
          if (!db_q[i]) begin
            state_d[i] = S_GAP;
            gap_d[i]   = '0;
          end else if (hold_q[i] == HOLD_W'(LONG_CYCLES - 1)) begin
            emit_c[i]      = 1'b1;
            emit_long_c[i] = 1'b1;
            state_d[i]     = S_LONGWAIT;
          end else begin
            hold_d[i] = hold_q[i] + 1'b1;
          end
        end
        S_GAP: begin
          if (db_q[i]) begin
            state_d[i] = S_HELD;
            cnt_d[i]   = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
            hold_d[i]  = '0;
          end else if (gap_q[i] == GAP_W'(TIMEOUT_CYCLES - 1)) begin
            emit_c[i]  = 1'b1;
            state_d[i] = S_IDLE;
          end else begin
            gap_d[i] = gap_q[i] + 1'b1;
          end
        end
        default: begin
          if (!db_q[i]) state_d[i] = S_IDLE;
        end
      endcase
    end
  end

  // Cyclic search for the first full slot at or after the round-robin pointer.
  always_comb begin
    int idx;
    idx         = 0;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    if (!res_valid_q || res_ready) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
        if (!grant_vld_c && slot_full_q[CH_W'(idx)]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = CH_W'(idx);
        end
      end
    end
  end

  // Pending slots and output register; a same-cycle free and write lets the write win.
  always_comb begin
    slot_full_d = slot_full_q;
    slot_long_d = slot_long_q;
    overflow_d  = overflow_q;
    res_valid_d = res_valid_q;
    res_ch_d    = res_ch_q;
    res_count_d = res_count_q;
    res_long_d  = res_long_q;
    rr_d        = rr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      slot_cnt_d[i] = slot_cnt_q[i];
      if (grant_vld_c && grant_idx_c == CH_W'(i)) slot_full_d[i] = 1'b0;
      if (emit_c[i]) begin
        if (slot_full_q[i] && !(grant_vld_c && grant_idx_c == CH_W'(i))) begin
          overflow_d[i] = 1'b1;
        end else begin
          slot_full_d[i] = 1'b1;
          slot_cnt_d[i]  = cnt_q[i];
          slot_long_d[i] = emit_long_c[i];
        end
      end
    end
    if (!res_valid_q || res_ready) begin
      res_valid_d = grant_vld_c;
      if (grant_vld_c) begin
        res_ch_d    = grant_idx_c;
        res_count_d = slot_cnt_q[grant_idx_c];
        res_long_d  = slot_long_q[grant_idx_c];
        rr_d        = (grant_idx_c == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_c + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      slot_full_q <= '0;
      slot_long_q <= '0;
      overflow_q  <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_count_q <= '0;
      res_long_q  <= 1'b0;
      rr_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        db_cnt_q[i]   <= '0;
        state_q[i]    <= S_IDLE;
        cnt_q[i]      <= '0;
        hold_q[i]     <= '0;
        gap_q[i]      <= '0;
        slot_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= button_raw;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      slot_full_q <= slot_full_d;
      slot_long_q <= slot_long_d;
      overflow_q  <= overflow_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_count_q <= res_count_d;
      res_long_q  <= res_long_d;
      rr_q        <= rr_d;
      for (int i = 0; i < NUM_CH; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        state_q[i]    <= state_d[i];
        cnt_q[i]      <= cnt_d[i];
        hold_q[i]     <= hold_d[i];
        gap_q[i]      <= gap_d[i];
        slot_cnt_q[i] <= slot_cnt_d[i];
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_count = res_count_q;
  assign res_long  = res_long_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_tap_gesture_counter_mc.sv
// Bench for tap_gesture_counter_mc: directed gesture scenarios and random button/backpressure
// traffic, compared every cycle against a behavioural model of levels, durations and slots.
module tb_tap_gesture_counter_mc;

  localparam int NCH = 2;
  localparam int DB  = 4;
  localparam int TO  = 20;
  localparam int LG  = 30;
  localparam int CW  = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] button_raw;
  logic           res_ready;
  logic           res_valid;
  logic [0:0]     res_ch;
  logic [CW-1:0]  res_count;
  logic           res_long;
  logic [NCH-1:0] overflow;

  tap_gesture_counter_mc #(
    .NUM_CH(NCH), .TIMEOUT_CYCLES(TO), .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LG), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .button_raw(button_raw),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_count(res_count), .res_long(res_long), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: delayed raw samples, debounced level with its run of disagreeing samples,
  // how long the FSM has seen the current level, taps so far, and per-channel pending results.
  int m_r1 [NCH], m_r2 [NCH], m_db [NCH], m_run [NCH];
  int m_seen [NCH], m_age [NCH], m_taps [NCH], m_longd [NCH];
  int p_full [NCH], p_cnt [NCH], p_long [NCH], m_ovf [NCH];
  int o_valid, o_ch, o_cnt, o_long, m_rr;

  int xf_ch [$];
  int xf_cnt [$];
  int xf_long [$];
  int valid_cycles;
  logic sat_seen_high;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_r1[c] = 0; m_r2[c] = 0; m_db[c] = 0; m_run[c] = 0;
      m_seen[c] = 0; m_age[c] = 0; m_taps[c] = 0; m_longd[c] = 0;
      p_full[c] = 0; p_cnt[c] = 0; p_long[c] = 0; m_ovf[c] = 0;
    end
    o_valid = 0; o_ch = 0; o_cnt = 0; o_long = 0; m_rr = 0;
  endtask

  task automatic model_step();
    int em [NCH];
    int ecnt [NCH];
    int elong [NCH];
    int v, gnt, idx;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      em[c] = 0; ecnt[c] = 0; elong[c] = 0;
      v = m_db[c];
      if (v == m_seen[c]) m_age[c]++;
      else begin m_age[c] = 1; m_seen[c] = v; end
      if (v != 0) begin
        if (m_age[c] == 1) m_taps[c] = (m_taps[c] == 0) ? 1 : ((m_taps[c] < CMAX) ? m_taps[c] + 1 : CMAX);
        if (m_age[c] == LG + 1 && m_longd[c] == 0) begin
          em[c] = 1; ecnt[c] = m_taps[c]; elong[c] = 1; m_longd[c] = 1;
        end
      end else begin
        if (m_age[c] == 1 && m_longd[c] != 0) begin m_longd[c] = 0; m_taps[c] = 0; end
        if (m_taps[c] > 0 && m_age[c] == TO + 1) begin
          em[c] = 1; ecnt[c] = m_taps[c]; elong[c] = 0; m_taps[c] = 0;
        end
      end
      // debounced level adopts the synchronised level after DB consecutive disagreeing samples
      if (m_r2[c] != m_db[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin m_db[c] = m_r2[c]; m_run[c] = 0; end
      end else m_run[c] = 0;
      m_r2[c] = m_r1[c];
      m_r1[c] = int'(button_raw[c]);
    end
    gnt = -1;
    if (o_valid == 0 || res_ready) begin
      for (int k = 0; k < NCH; k++) begin
        idx = (m_rr + k) % NCH;
        if (gnt < 0 && p_full[idx] != 0) gnt = idx;
      end
      o_valid = (gnt >= 0) ? 1 : 0;
      if (gnt >= 0) begin
        o_ch = gnt; o_cnt = p_cnt[gnt]; o_long = p_long[gnt]; m_rr = (gnt + 1) % NCH;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (em[c] != 0) begin
        if (p_full[c] != 0 && gnt != c) m_ovf[c] = 1;
        else begin p_full[c] = 1; p_cnt[c] = ecnt[c]; p_long[c] = elong[c]; end
      end else if (gnt == c) p_full[c] = 0;
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] ov;
    for (int c = 0; c < NCH; c++) ov[c] = (m_ovf[c] != 0);
    chk("res_valid", 32'(res_valid), 32'(o_valid));
    if (o_valid != 0) begin
      chk("res_ch", 32'(res_ch), 32'(o_ch));
      chk("res_count", 32'(res_count), 32'(o_cnt));
      chk("res_long", 32'(res_long), 32'(o_long));
    end
    chk("overflow", 32'(overflow), 32'(ov));
  endtask

  // One clock: log the handshake about to complete, advance the model, check at negedge.
  task automatic tick();
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      xf_ch.push_back(int'(res_ch));
      xf_cnt.push_back(int'(res_count));
      xf_long.push_back(int'(res_long));
      if (res_ch === 1'b1 && button_raw[1] === 1'b1) sat_seen_high = 1'b1;
    end
    if (res_valid === 1'b1) valid_cycles++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input logic [NCH-1:0] b, input int n);
    button_raw = b;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    xf_ch.delete(); xf_cnt.delete(); xf_long.delete();
    valid_cycles = 0;
  endtask

  initial begin
    rst = 1'b1; button_raw = '0; res_ready = 1'b1; sat_seen_high = 1'b0;
    model_reset(); clear_log();
    run(2'b00, 3);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_ch", 32'(res_ch), 32'd0);
    chk("rst_count", 32'(res_count), 32'd0);
    chk("rst_long", 32'(res_long), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    run(2'b00, 5);

    // Bounce reject: 2-cycle pulses never survive debouncing
    clear_log();
    for (int i = 0; i < 10; i++) begin run(2'b01, 2); run(2'b00, 2); end
    run(2'b00, 60);
    chk("bounce_xfers", 32'(xf_ch.size()), 32'd0);
    chk("bounce_ovf", 32'(overflow), 32'd0);

    // Triple tap on ch0
    clear_log();
    for (int i = 0; i < 3; i++) begin run(2'b01, 8); run(2'b00, 10); end
    run(2'b00, 40);
    chk("tri_xfers", 32'(xf_ch.size()), 32'd1);
    chk("tri_width", 32'(valid_cycles), 32'd1);
    if (xf_ch.size() >= 1) begin
      chk("tri_ch", 32'(xf_ch[0]), 32'd0);
      chk("tri_count", 32'(xf_cnt[0]), 32'd3);
      chk("tri_long", 32'(xf_long[0]), 32'd0);
    end

    // Saturation then long press on ch1
    clear_log(); sat_seen_high = 1'b0;
    for (int i = 0; i < 9; i++) begin run(2'b10, 6); run(2'b00, 6); end
    run(2'b10, 40);
    chk("long_while_high", 32'(sat_seen_high), 32'd1);
    run(2'b00, 60);
    chk("long_xfers", 32'(xf_ch.size()), 32'd1);
    if (xf_ch.size() >= 1) begin
      chk("long_ch", 32'(xf_ch[0]), 32'd1);
      chk("long_count", 32'(xf_cnt[0]), 32'd7);
      chk("long_flag", 32'(xf_long[0]), 32'd1);
    end

    // Backpressure and fairness: simultaneous gestures on both channels
    clear_log(); res_ready = 1'b0;
    run(2'b11, 8); run(2'b00, 30);
    run(2'b00, 5);
    chk("stall_valid", 32'(res_valid), 32'd1);
    chk("stall_ch", 32'(res_ch), 32'd0);
    chk("stall_count", 32'(res_count), 32'd1);
    chk("stall_long", 32'(res_long), 32'd0);
    res_ready = 1'b1;
    run(2'b00, 5);
    chk("fair_xfers", 32'(xf_ch.size()), 32'd2);
    if (xf_ch.size() >= 2) begin
      chk("fair_first", 32'(xf_ch[0]), 32'd0);
      chk("fair_second", 32'(xf_ch[1]), 32'd1);
      chk("fair_count", 32'(xf_cnt[1]), 32'd1);
    end

    // Overflow: three gestures on ch0 while stalled
    clear_log(); res_ready = 1'b0;
    run(2'b01, 8); run(2'b00, 30);
    for (int i = 0; i < 2; i++) begin run(2'b01, 8); run(2'b00, 10); end
    run(2'b00, 20);
    chk("ovf_before", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) begin run(2'b01, 8); run(2'b00, 10); end
    run(2'b00, 20);
    chk("ovf_after", 32'(overflow), 32'd1);
    res_ready = 1'b1;
    run(2'b00, 10);
    chk("ovf_xfers", 32'(xf_ch.size()), 32'd2);
    if (xf_ch.size() >= 2) begin
      chk("ovf_first", 32'(xf_cnt[0]), 32'd1);
      chk("ovf_second", 32'(xf_cnt[1]), 32'd2);
    end
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-gesture discards the pending two-tap gesture
    clear_log();
    run(2'b01, 8); run(2'b00, 10); run(2'b01, 8); run(2'b00, 8);
    rst = 1'b1;
    run(2'b00, 2);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    run(2'b00, 60);
    chk("mid_rst_xfers", 32'(xf_ch.size()), 32'd0);
    run(2'b01, 8); run(2'b00, 40);
    chk("post_rst_xfers", 32'(xf_ch.size()), 32'd1);
    if (xf_ch.size() >= 1) chk("post_rst_count", 32'(xf_cnt[0]), 32'd1);

    // Random presses, bounces and backpressure against the model
    for (int seg = 0; seg < 160; seg++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) run(2'($urandom_range(0, 3)), $urandom_range(1, 3));
      else run(2'($urandom_range(0, 3)), $urandom_range(4, 45));
    end
    res_ready = 1'b1;
    run(2'b00, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
